// File: rtl/dram_cim_pkg.sv
// Shared types and geometry for the DRAM CIM write path.
//   state_t : write controller sequence states
//   DRAM_ROWS / WBL_LANES / LANE_W / ADDR_W : array geometry
package dram_cim_pkg;

  localparam int unsigned DRAM_ROWS = 64;
  localparam int unsigned WBL_LANES = 16;
  localparam int unsigned LANE_W    = 64;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned WBL_W     = WBL_LANES * LANE_W;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DRIVE,
    WL,
    REC,
    ACK
  } state_t;

endpackage

// File: rtl/dram_wbl_write_ctrl_if.sv
// Bundle between the init streamer, the write controller and the DRAM array.
//   slave  : controller side (takes IO_EN/ADDR/WBL_DATA*, drives wr_done,
//            DRAM_* controls, BUSY, WR_CNT, SEQ_ERR)
//   master : upstream/array side (opposite directions)
interface dram_wbl_write_ctrl_if;
  import dram_cim_pkg::*;

  logic              IO_EN;
  logic [ADDR_W-1:0] ADDR;
  logic [LANE_W-1:0] WBL_DATA1,  WBL_DATA2,  WBL_DATA3,  WBL_DATA4;
  logic [LANE_W-1:0] WBL_DATA5,  WBL_DATA6,  WBL_DATA7,  WBL_DATA8;
  logic [LANE_W-1:0] WBL_DATA9,  WBL_DATA10, WBL_DATA11, WBL_DATA12;
  logic [LANE_W-1:0] WBL_DATA13, WBL_DATA14, WBL_DATA15, WBL_DATA16;

  logic              wr_done;
  logic              DRAM_PRE;
  logic              DRAM_WBL_EN;
  logic              DRAM_WL_EN;
  logic [ADDR_W-1:0] DRAM_WL_ADDR;
  logic [WBL_W-1:0]  DRAM_WBL;
  logic              BUSY;
  logic [6:0]        WR_CNT;
  logic              SEQ_ERR;

  modport slave (
    input  IO_EN, ADDR,
    input  WBL_DATA1,  WBL_DATA2,  WBL_DATA3,  WBL_DATA4,
    input  WBL_DATA5,  WBL_DATA6,  WBL_DATA7,  WBL_DATA8,
    input  WBL_DATA9,  WBL_DATA10, WBL_DATA11, WBL_DATA12,
    input  WBL_DATA13, WBL_DATA14, WBL_DATA15, WBL_DATA16,
    output wr_done, DRAM_PRE, DRAM_WBL_EN, DRAM_WL_EN, DRAM_WL_ADDR,
    output DRAM_WBL, BUSY, WR_CNT, SEQ_ERR
  );

  modport master (
    output IO_EN, ADDR,
    output WBL_DATA1,  WBL_DATA2,  WBL_DATA3,  WBL_DATA4,
    output WBL_DATA5,  WBL_DATA6,  WBL_DATA7,  WBL_DATA8,
    output WBL_DATA9,  WBL_DATA10, WBL_DATA11, WBL_DATA12,
    output WBL_DATA13, WBL_DATA14, WBL_DATA15, WBL_DATA16,
    input  wr_done, DRAM_PRE, DRAM_WBL_EN, DRAM_WL_EN, DRAM_WL_ADDR,
    input  DRAM_WBL, BUSY, WR_CNT, SEQ_ERR
  );

endinterface

// File: rtl/dram_wr_timer.sv
// 4-bit loadable down-counter timing the PRE/WL/REC phases.
//   CLK, RSTn   : clock, async active-low reset
//   load_i      : load load_val_i this edge (has priority over counting)
//   load_val_i  : zero-based phase length
//   zero_o      : counter has reached 0 (current phase ends this cycle)
module dram_wr_timer (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;

  // Counts down freely and parks at 0; every phase that uses it loads first.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)              cnt_q <= '0;
    else if (load_i)        cnt_q <= load_val_i;
    else if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/dram_wbl_write_ctrl.sv
// DRAM row write sequencer: captures one 1024-bit word per IO_EN handshake
// and walks precharge -> bitline drive -> wordline pulse -> recovery -> ack.
//   CLK, RSTn : clock, async active-low reset
//   bus       : slave side of dram_wbl_write_ctrl_if (upstream word in,
//               wr_done back, DRAM controls/data out, BUSY/WR_CNT/SEQ_ERR)
module dram_wbl_write_ctrl
  import dram_cim_pkg::*;
#(
  parameter int unsigned PRE_CYC = 2,
  parameter int unsigned WL_CYC  = 4,
  parameter int unsigned REC_CYC = 2
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  dram_wbl_write_ctrl_if.slave  bus
);

  state_t            state_q, state_d;
  logic              tmr_load, tmr_zero, capture;
  logic [3:0]        tmr_val;
  logic [ADDR_W-1:0] addr_q, exp_addr_q;
  logic [WBL_W-1:0]  wbl_q;
  logic [6:0]        cnt_q;
  logic              seq_err_q;

  dram_wr_timer u_timer (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    capture  = 1'b0;
    case (state_q)
      IDLE: if (bus.IO_EN) begin
        capture  = 1'b1;
        tmr_load = 1'b1;
        tmr_val  = 4'(PRE_CYC - 1);
        state_d  = PRE;
      end
      PRE:  if (tmr_zero) state_d = DRIVE;
      DRIVE: begin
        tmr_load = 1'b1;
        tmr_val  = 4'(WL_CYC - 1);
        state_d  = WL;
      end
      WL: if (tmr_zero) begin
        tmr_load = 1'b1;
        tmr_val  = 4'(REC_CYC - 1);
        state_d  = REC;
      end
      REC:  if (tmr_zero) state_d = ACK;
      ACK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      addr_q     <= '0;
      wbl_q      <= '0;
      exp_addr_q <= '0;
      cnt_q      <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      if (capture) begin
        addr_q <= bus.ADDR;
        wbl_q  <= {bus.WBL_DATA16, bus.WBL_DATA15, bus.WBL_DATA14, bus.WBL_DATA13,
                   bus.WBL_DATA12, bus.WBL_DATA11, bus.WBL_DATA10, bus.WBL_DATA9,
                   bus.WBL_DATA8,  bus.WBL_DATA7,  bus.WBL_DATA6,  bus.WBL_DATA5,
                   bus.WBL_DATA4,  bus.WBL_DATA3,  bus.WBL_DATA2,  bus.WBL_DATA1};
        if (bus.ADDR != exp_addr_q) seq_err_q <= 1'b1;
      end
      if (state_q == ACK) begin
        exp_addr_q <= addr_q + 1'b1;
        if (cnt_q != '1) cnt_q <= cnt_q + 7'd1;
      end
    end
  end

  assign bus.wr_done      = (state_q == ACK);
  assign bus.DRAM_PRE     = (state_q == PRE);
  assign bus.DRAM_WBL_EN  = (state_q == DRIVE) || (state_q == WL) || (state_q == REC);
  assign bus.DRAM_WL_EN   = (state_q == WL);
  assign bus.BUSY         = (state_q != IDLE);
  assign bus.DRAM_WL_ADDR = addr_q;
  assign bus.DRAM_WBL     = wbl_q;
  assign bus.WR_CNT       = cnt_q;
  assign bus.SEQ_ERR      = seq_err_q;

endmodule

// File: tb/tb_dram_wbl_write_ctrl.sv
module tb_dram_wbl_write_ctrl;
  import dram_cim_pkg::*;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic          io_en = 1'b0;
  logic [5:0]    addr  = '0;
  logic [1023:0] din   = '0;

  dram_wbl_write_ctrl_if bus0 ();
  dram_wbl_write_ctrl_if bus1 ();

  // Both DUTs see identical upstream inputs; each has its own model.
  assign bus0.IO_EN = io_en;              assign bus1.IO_EN = io_en;
  assign bus0.ADDR  = addr;               assign bus1.ADDR  = addr;
  assign bus0.WBL_DATA1  = din[63:0];     assign bus1.WBL_DATA1  = din[63:0];
  assign bus0.WBL_DATA2  = din[127:64];   assign bus1.WBL_DATA2  = din[127:64];
  assign bus0.WBL_DATA3  = din[191:128];  assign bus1.WBL_DATA3  = din[191:128];
  assign bus0.WBL_DATA4  = din[255:192];  assign bus1.WBL_DATA4  = din[255:192];
  assign bus0.WBL_DATA5  = din[319:256];  assign bus1.WBL_DATA5  = din[319:256];
  assign bus0.WBL_DATA6  = din[383:320];  assign bus1.WBL_DATA6  = din[383:320];
  assign bus0.WBL_DATA7  = din[447:384];  assign bus1.WBL_DATA7  = din[447:384];
  assign bus0.WBL_DATA8  = din[511:448];  assign bus1.WBL_DATA8  = din[511:448];
  assign bus0.WBL_DATA9  = din[575:512];  assign bus1.WBL_DATA9  = din[575:512];
  assign bus0.WBL_DATA10 = din[639:576];  assign bus1.WBL_DATA10 = din[639:576];
  assign bus0.WBL_DATA11 = din[703:640];  assign bus1.WBL_DATA11 = din[703:640];
  assign bus0.WBL_DATA12 = din[767:704];  assign bus1.WBL_DATA12 = din[767:704];
  assign bus0.WBL_DATA13 = din[831:768];  assign bus1.WBL_DATA13 = din[831:768];
  assign bus0.WBL_DATA14 = din[895:832];  assign bus1.WBL_DATA14 = din[895:832];
  assign bus0.WBL_DATA15 = din[959:896];  assign bus1.WBL_DATA15 = din[959:896];
  assign bus0.WBL_DATA16 = din[1023:960]; assign bus1.WBL_DATA16 = din[1023:960];

  dram_wbl_write_ctrl #(.PRE_CYC(2), .WL_CYC(4), .REC_CYC(2)) u_dut0 (
    .CLK(CLK), .RSTn(RSTn), .bus(bus0));
  dram_wbl_write_ctrl #(.PRE_CYC(1), .WL_CYC(1), .REC_CYC(1)) u_dut1 (
    .CLK(CLK), .RSTn(RSTn), .bus(bus1));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: time since capture edge k decides the phase.
  //   k in [0,P) PRE, k==P DRIVE, (P,P+W] WL, (P+W,P+W+R] REC, P+W+R+1 ACK.
  int            P [2] = '{2, 1};
  int            W [2] = '{4, 1};
  int            R [2] = '{2, 1};
  bit            m_act [2];
  int            m_k   [2];
  int            m_cnt [2];
  bit            m_err [2];
  logic [5:0]    m_exp [2];
  logic [5:0]    m_addr[2];
  logic [1023:0] m_wbl [2];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_k[i] = 0; m_cnt[i] = 0; m_err[i] = 0;
      m_exp[i] = '0; m_addr[i] = '0; m_wbl[i] = '0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!m_act[i]) begin
        if (io_en) begin
          m_act[i] = 1; m_k[i] = 0;
          if (addr != m_exp[i]) m_err[i] = 1;
          m_addr[i] = addr; m_wbl[i] = din;
        end
      end else begin
        m_k[i]++;
        if (m_k[i] == P[i] + W[i] + R[i] + 2) begin
          m_act[i] = 0;
          if (m_cnt[i] < 127) m_cnt[i]++;
          m_exp[i] = m_addr[i] + 6'd1;
        end
      end
    end
  endfunction

  // {wr_done, PRE, WBL_EN, WL_EN, BUSY, SEQ_ERR}
  function automatic logic [5:0] exp_ctrl(input int i);
    int k, p, w, r;
    bit a;
    k = m_k[i]; p = P[i]; w = W[i]; r = R[i]; a = m_act[i];
    return {a && k == p + w + r + 1, a && k < p, a && k >= p && k <= p + w + r,
            a && k > p && k <= p + w, a, m_err[i]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_wbl(input string name, input logic [1023:0] act, input logic [1023:0] req);
    vectors++;
    if (act !== req) begin
      int l;
      l = 0;
      for (int j = 15; j >= 0; j--) if (act[j*64 +: 64] !== req[j*64 +: 64]) l = j;
      miscompares++;
      $display("FAIL %s: lane %0d got %h expected %h (t=%0t)", name, l + 1,
               act[l*64 +: 64], req[l*64 +: 64], $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      logic [5:0] c; logic [6:0] n; logic [5:0] wa; logic [1023:0] w;
      if (i == 0) begin
        c  = {bus0.wr_done, bus0.DRAM_PRE, bus0.DRAM_WBL_EN, bus0.DRAM_WL_EN, bus0.BUSY, bus0.SEQ_ERR};
        n  = bus0.WR_CNT; wa = bus0.DRAM_WL_ADDR; w = bus0.DRAM_WBL;
      end else begin
        c  = {bus1.wr_done, bus1.DRAM_PRE, bus1.DRAM_WBL_EN, bus1.DRAM_WL_EN, bus1.BUSY, bus1.SEQ_ERR};
        n  = bus1.WR_CNT; wa = bus1.DRAM_WL_ADDR; w = bus1.DRAM_WBL;
      end
      chk($sformatf("dut%0d ctrl{done,pre,wbl,wl,busy,err}", i), 64'(c), 64'(exp_ctrl(i)));
      chk($sformatf("dut%0d WR_CNT", i), 64'(n), 64'(m_cnt[i]));
      chk($sformatf("dut%0d DRAM_WL_ADDR", i), 64'(wa), 64'(m_addr[i]));
      chk_wbl($sformatf("dut%0d DRAM_WBL", i), w, m_wbl[i]);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    if (RSTn) model_edge();
    #1;
    check_all();
  endtask

  function automatic logic [1023:0] lane_pat();
    logic [1023:0] d;
    for (int k = 1; k <= 16; k++) d[(k-1)*64 +: 64] = 64'(k) * 64'h0101010101010101;
    return d;
  endfunction

  function automatic logic [1023:0] rand_data();
    logic [1023:0] d;
    for (int j = 0; j < 32; j++) d[j*32 +: 32] = $urandom();
    return d;
  endfunction

  // Wait (bounded) for DUT0's wr_done, then one more edge so DUT0 sits in IDLE.
  task automatic wait_done0(input string name);
    int n;
    n = 0;
    while (!bus0.wr_done && n < 40) begin step(); n++; end
    chk(name, 64'(bus0.wr_done), 64'd1);
    step();
  endtask

  task automatic do_reset();
    #1 RSTn = 1'b0;
    io_en = 1'b0;
    #1 model_reset();
    check_all();
    step(); step();
    RSTn = 1'b1;
  endtask

  typedef struct {
    logic [5:0] addr;
    bit         err;
    int         cnt;
  } vec_t;

  vec_t skip_tbl [3];

  initial begin
    int p0, b0, l0, d0, de0, p1, b1, l1, d1, de1;
    int cycles, words, extra;
    logic [1023:0] saved;

    skip_tbl[0] = '{6'd0, 1'b0, 1};
    skip_tbl[1] = '{6'd1, 1'b0, 2};
    skip_tbl[2] = '{6'd3, 1'b1, 3};

    // Reset state
    model_reset();
    #1 check_all();
    step(); step();
    RSTn = 1'b1;
    step();

    // Single word: phase lengths and wr_done latency on both parameter sets
    io_en = 1'b1; addr = 6'd0; din = lane_pat();
    step();
    io_en = 1'b0;
    p0 = 0; b0 = 0; l0 = 0; d0 = 0; de0 = -1;
    p1 = 0; b1 = 0; l1 = 0; d1 = 0; de1 = -1;
    for (int e = 0; e < 16; e++) begin
      p0 += int'(bus0.DRAM_PRE); b0 += int'(bus0.DRAM_WBL_EN); l0 += int'(bus0.DRAM_WL_EN);
      p1 += int'(bus1.DRAM_PRE); b1 += int'(bus1.DRAM_WBL_EN); l1 += int'(bus1.DRAM_WL_EN);
      if (bus0.wr_done) begin d0++; de0 = e; end
      if (bus1.wr_done) begin d1++; de1 = e; end
      step();
    end
    chk("single PRE cycles",    64'(p0), 64'd2);
    chk("single WBL_EN cycles", 64'(b0), 64'd7);
    chk("single WL_EN cycles",  64'(l0), 64'd4);
    chk("single wr_done count", 64'(d0), 64'd1);
    chk("single wr_done edge",  64'(de0), 64'd9);
    chk("single lane16",        bus0.DRAM_WBL[1023:960], 64'h1010101010101010);
    chk("sweep PRE cycles",     64'(p1), 64'd1);
    chk("sweep WBL_EN cycles",  64'(b1), 64'd3);
    chk("sweep WL_EN cycles",   64'(l1), 64'd1);
    chk("sweep wr_done count",  64'(d1), 64'd1);
    chk("sweep wr_done edge",   64'(de1), 64'd4);

    // Address skip 0,1,3 from a clean reset
    do_reset();
    step();
    for (int v = 0; v < 3; v++) begin
      io_en = 1'b1; addr = skip_tbl[v].addr; din = rand_data();
      step();
      io_en = 1'b0;
      chk($sformatf("skip[%0d] SEQ_ERR at capture", v), 64'(bus0.SEQ_ERR), 64'(skip_tbl[v].err));
      wait_done0($sformatf("skip[%0d] wr_done", v));
      chk($sformatf("skip[%0d] WR_CNT", v), 64'(bus0.WR_CNT), 64'(skip_tbl[v].cnt));
      chk($sformatf("skip[%0d] SEQ_ERR after", v), 64'(bus0.SEQ_ERR), 64'(skip_tbl[v].err));
    end

    // Inputs changing during WL are ignored
    io_en = 1'b1; addr = 6'd4; din = rand_data(); saved = din;
    step();
    for (int n = 0; n < 20 && !bus0.DRAM_WL_EN; n++) step();
    chk("midwrite reached WL", 64'(bus0.DRAM_WL_EN), 64'd1);
    io_en = 1'b0; addr = 6'd9; din = rand_data();
    step();
    io_en = 1'b1;
    step();
    io_en = 1'b0;
    chk("midwrite WL_ADDR held", 64'(bus0.DRAM_WL_ADDR), 64'd4);
    chk_wbl("midwrite WBL held", bus0.DRAM_WBL, saved);
    wait_done0("midwrite wr_done");

    // Reset during WL
    io_en = 1'b1; addr = 6'd5; din = rand_data();
    step();
    io_en = 1'b0;
    for (int n = 0; n < 20 && !bus0.DRAM_WL_EN; n++) step();
    chk("rst reached WL", 64'(bus0.DRAM_WL_EN), 64'd1);
    #1 RSTn = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst BUSY", 64'(bus0.BUSY), 64'd0);
    chk("rst WBL lane1", bus0.DRAM_WBL[63:0], 64'd0);
    step();
    RSTn = 1'b1;
    io_en = 1'b1; addr = 6'd0; din = rand_data();
    step();
    io_en = 1'b0;
    wait_done0("post-rst wr_done");
    chk("post-rst SEQ_ERR", 64'(bus0.SEQ_ERR), 64'd0);
    chk("post-rst WR_CNT",  64'(bus0.WR_CNT), 64'd1);

    // Full 64-word stream with an upstream that advances on wr_done
    do_reset();
    step();
    io_en = 1'b1; addr = 6'd0; din = lane_pat() ^ rand_data();
    cycles = 0; words = 0;
    for (int n = 0; n < 2000; n++) begin
      step();
      cycles++;
      if (bus0.wr_done) begin
        words++;
        if (words == 64) io_en = 1'b0;
        else begin addr = addr + 6'd1; din = rand_data(); end
      end
      if (words == 64 && !bus0.BUSY) break;
    end
    // Counted from the capture cycle through the IDLE cycle after the last ACK
    chk("stream cycles",  64'(cycles), 64'd704);
    chk("stream words",   64'(words), 64'd64);
    chk("stream WR_CNT",  64'(bus0.WR_CNT), 64'd64);
    chk("stream SEQ_ERR", 64'(bus0.SEQ_ERR), 64'd0);
    chk("stream last WL_ADDR", 64'(bus0.DRAM_WL_ADDR), 64'd63);
    extra = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      extra += int'(bus0.wr_done);
    end
    chk("stream pulses after IO_EN low", 64'(extra), 64'd0);

    // Randomized traffic against the model (drives WR_CNT into saturation)
    for (int n = 0; n < 2500; n++) begin
      io_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) addr = 6'($urandom());
      else if (bus0.wr_done) addr = addr + 6'd1;
      din = rand_data();
      step();
    end
    chk("random dut1 WR_CNT saturated", 64'(bus1.WR_CNT), 64'd127);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dram_wbl_write_ctrl.md
Name: dram_wbl_write_ctrl

Overview:
- Downstream consumer of the DRAM key/S-box init streamer.
- Accepts one 1024-bit word per handshake: IO_EN, ADDR and the 16 lanes WBL_DATA1..16.
- Sequences the physical DRAM row write in this order: precharge, bitline drive, wordline pulse, recovery.
- Returns a one-cycle wr_done to the streamer, which advances its address on that pulse.
- Also counts completed writes and flags out-of-order addresses.

Parameters:
- PRE_CYC, 2, precharge cycles (1..15)
- WL_CYC, 4, wordline-high cycles (1..15)
- REC_CYC, 2, recovery cycles with WL low and WBL still driven (1..15)

Ports:
- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- IO_EN  in  1  upstream word valid / stream active
- ADDR  in  6  upstream row address
- WBL_DATA1..WBL_DATA16  in  64 each  upstream lane data
- wr_done  out  1  one-cycle pulse: current word written
- DRAM_PRE  out  1  bitline precharge enable
- DRAM_WBL_EN  out  1  write-bitline driver enable
- DRAM_WL_EN  out  1  wordline enable
- DRAM_WL_ADDR  out  6  captured row address
- DRAM_WBL  out  1024  captured data; WBL_DATA1 at [63:0], WBL_DATA16 at [1023:960]
- BUSY  out  1  high in every state except IDLE
- WR_CNT  out  7  completed writes, saturating at 127
- SEQ_ERR  out  1  sticky out-of-order address flag

Behaviour:
- Reset is asynchronous. All outputs go to 0, state goes to IDLE, expected address goes to 0, and any write in flight is abandoned.
- State sequence: IDLE -> PRE -> DRIVE -> WL -> REC -> ACK -> IDLE. One loadable down-counter times PRE, WL and REC.
- IDLE:
  - If IO_EN=1 at a clock edge, capture ADDR and all 16 lanes into internal registers and go to PRE with counter=PRE_CYC-1.
  - If IO_EN=0, stay in IDLE.
- PRE: DRAM_PRE=1 for PRE_CYC cycles, then DRIVE.
- DRIVE: DRAM_WBL_EN=1 for exactly 1 setup cycle, then WL with counter=WL_CYC-1.
- WL: DRAM_WBL_EN=1 and DRAM_WL_EN=1 for WL_CYC cycles, then REC.
- REC: DRAM_WBL_EN=1 and DRAM_WL_EN=0 for REC_CYC cycles, then ACK.
- ACK:
  - wr_done=1 for exactly one cycle.
  - WR_CNT increments unless already at 127.
  - Expected address becomes captured address + 1, mod 64.
  - Next state is IDLE.
- Timing:
  - wr_done is high in the cycle starting PRE_CYC+WL_CYC+REC_CYC+1 edges after the capture edge (9 with defaults).
  - The mandatory IDLE cycle after ACK lets the upstream registered update settle.
  - Word period is PRE_CYC+WL_CYC+REC_CYC+3 cycles (11 with defaults); 64 words take 704 cycles.
- Control outputs come from registered state decode. DRAM_PRE, DRAM_WBL_EN and DRAM_WL_EN are mutually exclusive except that WBL_EN and WL_EN overlap in WL. No combinational path exists from inputs to outputs.
- DRAM_WBL and DRAM_WL_ADDR change only at a capture edge and hold until the next capture.
- IO_EN or ADDR/data changing while not in IDLE: ignored. The current write completes with the captured data and wr_done still pulses.
- IO_EN low after the last word (upstream has deasserted): stay in IDLE with no further pulses.
- SEQ_ERR: set at a capture edge if ADDR != expected address. Cleared only by reset. The write still proceeds.
- Counter arithmetic: 4-bit counter, zero-based. A state exits when counter==0.

Decomposition:
- Package dram_cim_pkg:
  - state enum: IDLE, PRE, DRIVE, WL, REC, ACK
  - DRAM_ROWS=64, WBL_LANES=16, LANE_W=64, ADDR_W=6
- Sub-module dram_wr_timer: 4-bit loadable down-counter with load, load value and zero flag. Instantiated once.

Test Plan:
- Single word: IO_EN=1, ADDR=0, lanes=k*0x0101..., defaults. Required response:
  - DRAM_PRE high 2 cycles, WBL_EN high 7 cycles, WL_EN high 4 cycles.
  - wr_done is a single pulse 9 edges after capture.
  - DRAM_WBL[1023:960] equals WBL_DATA16.
- Full stream with a behavioural upstream model (START, advance on wr_done, 64 words). Required response:
  - 64 wr_done pulses, 704 cycles total.
  - WR_CNT=64, SEQ_ERR=0.
  - Final DRAM_WL_ADDR=63, no pulse after IO_EN drops.
- Mid-write input change: toggle IO_EN low and change ADDR/data during WL. Required response: DRAM_WBL and DRAM_WL_ADDR unchanged, wr_done still pulses.
- Address skip: feed 0,1,3. Required response: SEQ_ERR rises at the capture of 3 and stays high; all three writes still complete.
- Reset mid-operation: assert RSTn low during WL. Required response:
  - All outputs 0 immediately, BUSY=0.
  - After release with IO_EN=1, ADDR=0, a clean write occurs with SEQ_ERR=0.
- Parameter sweep PRE_CYC=1, WL_CYC=1, REC_CYC=1. Required response: period 6 cycles, each phase exactly 1 cycle, wr_done 4 edges after capture.
